// File: rtl/ft_pipe_adder.sv
// ft_pipe_adder: pipelined, triple-replicated WIDTH-bit adder/subtractor.
// One pipeline stage per SEG-bit segment. The carry ripples stage to stage. Each stage
// votes three replica results bitwise and flags any disagreement with the transaction.
// A single advance signal stalls the whole pipe on downstream back-pressure.
module ft_pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SEG    = 4,
    parameter int unsigned ECNT_W = 8
) (
    input  logic              IN_CLK,
    input  logic              IN_RST_N,
    input  logic              IN_VALID,
    output logic              OUT_READY,
    input  logic [WIDTH-1:0]  IN_A,
    input  logic [WIDTH-1:0]  IN_B,
    input  logic              IN_CIN,
    input  logic              IN_SUB,
    input  logic [2:0]        IN_FI_MASK,
    output logic              OUT_VALID,
    input  logic              IN_READY,
    output logic [WIDTH-1:0]  OUT_SUM,
    output logic              OUT_COUT,
    output logic              OUT_OVF,
    output logic              OUT_ERR,
    output logic [ECNT_W-1:0] OUT_ERR_CNT
);

    localparam int unsigned NSTG = WIDTH / SEG;
    localparam int unsigned MSB  = WIDTH - 1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEG:0]     rep_t;   // {carry_out, sum_segment}

    // Pipeline registers: stage k holds the transaction after segment k is computed.
    logic [NSTG-1:0] vld_q;
    logic [NSTG-1:0] cy_q;
    logic [NSTG-1:0] err_q;
    word_t           a_q   [NSTG];
    word_t           bp_q  [NSTG];
    word_t           sum_q [NSTG];
    logic [ECNT_W-1:0] ecnt_q;

    // Stage inputs: stage 0 is fed from the prepared operands, stage k from register k-1.
    logic [NSTG-1:0] vld_in;
    logic [NSTG-1:0] cy_in;
    logic [NSTG-1:0] err_in;
    word_t           a_in   [NSTG];
    word_t           bp_in  [NSTG];
    word_t           sum_in [NSTG];

    // Stage results after voting.
    rep_t            rep    [NSTG][3];
    rep_t            voted  [NSTG];
    logic [NSTG-1:0] cy_d;
    logic [NSTG-1:0] err_d;
    word_t           sum_d  [NSTG];

    logic adv;
    logic xfer_out;

    // One replica: plain segment add with carry-in.
    function automatic rep_t replica(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                     input logic c);
        replica = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    // Bitwise 2-of-3 majority.
    function automatic rep_t vote(input rep_t x, input rep_t y, input rep_t z);
        vote = (x & y) | (y & z) | (x & z);
    endfunction

    // The whole pipe moves together; nothing moves while a result is waiting.
    assign adv       = !vld_q[NSTG-1] || IN_READY;
    assign OUT_READY = adv;
    assign xfer_out  = vld_q[NSTG-1] && IN_READY;

    // Select the stage inputs: operand preparation for stage 0, previous register otherwise.
    always_comb begin
        vld_in[0] = IN_VALID;
        a_in[0]   = IN_A;
        // Subtraction as A + ~B + 1; the incoming carry is ignored in that mode.
        bp_in[0]  = IN_SUB ? ~IN_B : IN_B;
        cy_in[0]  = IN_SUB ? 1'b1 : IN_CIN;
        sum_in[0] = '0;
        err_in[0] = 1'b0;
        for (int k = 1; k < NSTG; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            bp_in[k]  = bp_q[k-1];
            cy_in[k]  = cy_q[k-1];
            sum_in[k] = sum_q[k-1];
            err_in[k] = err_q[k-1];
        end
    end

    // Replicated segment add, fault injection on replica carries, voting and error detect.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            for (int r = 0; r < 3; r++) begin
                rep[k][r] = replica(a_in[k][k*SEG +: SEG], bp_in[k][k*SEG +: SEG], cy_in[k]);
                rep[k][r][SEG] = rep[k][r][SEG] ^ IN_FI_MASK[r];
            end
            voted[k] = vote(rep[k][0], rep[k][1], rep[k][2]);
            // Earlier segments ride through untouched; only this stage's slice is replaced.
            sum_d[k] = sum_in[k];
            sum_d[k][k*SEG +: SEG] = voted[k][SEG-1:0];
            cy_d[k]  = voted[k][SEG];
            err_d[k] = err_in[k] |
                       (|((rep[k][0] ^ rep[k][1]) | (rep[k][1] ^ rep[k][2])));
        end
    end

    // Pipeline state: valid bits shift on advance, payload loads only with a valid entry.
    always_ff @(posedge IN_CLK) begin
        if (!IN_RST_N) begin
            vld_q <= '0;
            cy_q  <= '0;
            err_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_in;
            for (int k = 0; k < NSTG; k++) begin
                if (vld_in[k]) begin
                    a_q[k]   <= a_in[k];
                    bp_q[k]  <= bp_in[k];
                    sum_q[k] <= sum_d[k];
                    cy_q[k]  <= cy_d[k];
                    err_q[k] <= err_d[k];
                end
            end
        end
    end

    // Saturating count of erroneous results actually handed downstream.
    always_ff @(posedge IN_CLK) begin
        if (!IN_RST_N) begin
            ecnt_q <= '0;
        end else if (xfer_out && err_q[NSTG-1] && (ecnt_q != {ECNT_W{1'b1}})) begin
            ecnt_q <= ecnt_q + 1'b1;
        end
    end

    assign OUT_VALID   = vld_q[NSTG-1];
    assign OUT_SUM     = sum_q[NSTG-1];
    assign OUT_COUT    = cy_q[NSTG-1];
    // Signed overflow: like-signed operands giving a result of the other sign.
    assign OUT_OVF     = (a_q[NSTG-1][MSB] == bp_q[NSTG-1][MSB]) &&
                         (sum_q[NSTG-1][MSB] != a_q[NSTG-1][MSB]);
    assign OUT_ERR     = vld_q[NSTG-1] && err_q[NSTG-1];
    assign OUT_ERR_CNT = ecnt_q;

endmodule

// File: doc/ft_pipe_adder.md
Name: ft_pipe_adder

Overview:
- Parametrised, pipelined, fault-tolerant WIDTH-bit adder/subtractor for the fault-tolerant ALU datapath; successor to the single-bit full adder.
- Splits operands into SEG-bit segments, one pipeline stage per segment, with the carry rippling stage to stage.
- Each stage computes with three replicas and a bitwise majority voter; disagreements are flagged per transaction and counted.
- Valid/ready handshake on both sides, with full-pipeline stall on downstream back-pressure.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SEG
SEG, 4, bits per pipeline stage; NSTG = WIDTH/SEG stages (>=1)
ECNT_W, 8, width of saturating error counter

Ports:
IN_CLK  input  1  clock, rising edge
IN_RST_N  input  1  reset, synchronous, active-low
IN_VALID  input  1  upstream operands valid
OUT_READY  output  1  block accepts operands this cycle
IN_A  input  WIDTH  operand A
IN_B  input  WIDTH  operand B
IN_CIN  input  1  carry-in (add mode only)
IN_SUB  input  1  1 = compute A - B
IN_FI_MASK  input  3  fault injection; bit r inverts replica r carry-out in every stage
OUT_VALID  output  1  result valid
IN_READY  input  1  downstream accepts result
OUT_SUM  output  WIDTH  voted sum
OUT_COUT  output  1  voted final carry-out
OUT_OVF  output  1  signed overflow
OUT_ERR  output  1  replica disagreement seen anywhere in this transaction
OUT_ERR_CNT  output  ECNT_W  saturating count of delivered erroneous results

Behaviour:
- Reset: IN_RST_N sampled low at a rising edge clears all stage valid bits and data registers. OUT_VALID, OUT_SUM, OUT_COUT, OUT_OVF, OUT_ERR and OUT_ERR_CNT are all 0 after reset. Reset mid-operation discards in-flight transactions; none emerge afterwards.
- Advance: adv = !OUT_VALID || IN_READY. OUT_READY = adv (combinational from IN_READY). Transfer in = IN_VALID && OUT_READY. Transfer out = OUT_VALID && IN_READY. When adv=0, every stage holds.
- Operand preparation at entry:
  - Add mode: B' = IN_B, c0 = IN_CIN.
  - Sub mode (IN_SUB=1): B' = ~IN_B, c0 = 1; IN_CIN is ignored.
  - A, B', c0 and the B' MSB / A MSB are carried down the pipe with the transaction.
- Stage k (0..NSTG-1):
  - Inputs: A[k*SEG +: SEG], B'[k*SEG +: SEG], carry from stage k-1 (c0 for k=0).
  - Three identical replicas each produce a SEG-bit sum and a carry-out. Replica r's carry-out is inverted when IN_FI_MASK[r]=1.
  - The sum is voted bitwise (majority of 3) and the carry-out is voted likewise. Voted values are registered on adv.
  - Stage error = any bit where replicas disagree. The transaction error flag is ORed with the stage error and registered.
  - Already-computed sum segments pass through unchanged.
- Latency: NSTG cycles from input transfer to OUT_VALID, absent stalls. Throughput is 1 per cycle when IN_READY=1. Order is preserved.
- Outputs:
  - OUT_SUM = concatenated voted segments.
  - OUT_COUT = voted carry of the last stage; in sub mode, 1 means no borrow.
  - OUT_OVF = (A[MSB] == B'[MSB]) && (OUT_SUM[MSB] != A[MSB]).
  - OUT_ERR is valid only while OUT_VALID=1.
  - OUT_ERR_CNT increments by 1 on each transfer out with OUT_ERR=1 and saturates at 2^ECNT_W-1. Only reset clears it.
- Fault tolerance:
  - Exactly one replica faulted: the voter corrects it, the result is exact, and OUT_ERR=1.
  - Two or more replicas faulted: the result may be wrong, but OUT_ERR=1 whenever any disagreement occurs.
  - IN_FI_MASK=0 never sets OUT_ERR.
- Simultaneous transfer in and out in the same cycle is legal; the pipe shifts by one.
- Outputs hold stable while OUT_VALID=1 and IN_READY=0.

Test Plan:
WIDTH=16, SEG=4 (latency 4) for all scenarios.
1. Add 0x1234 + 0x0FFF, CIN=0, SUB=0 -> 4 cycles later OUT_SUM=0x2233, COUT=0, OVF=0, ERR=0.
2. Add 0xFFFF + 0x0001, CIN=0 (carry ripples all 4 stages) -> OUT_SUM=0x0000, COUT=1, OVF=0. Repeat with 0x7FFF + 0x0001 -> 0x8000, COUT=0, OVF=1.
3. Sub: A=0x8000, B=0x0001, SUB=1, CIN=1 -> OUT_SUM=0x7FFF, COUT=1, OVF=1. Then A=0x0003, B=0x0005 -> 0xFFFE, COUT=0, OVF=0.
4. IN_FI_MASK=3'b010, A=0x00FF, B=0x0001 -> OUT_SUM=0x0100 exact, OUT_ERR=1, ERR_CNT 0->1. Then MASK=0 transaction -> ERR=0, count stays 1.
5. Six back-to-back transactions, IN_READY held low for 3 cycles once the first result appears -> OUT_READY=0 during the stall, outputs stable, all 6 results delivered in order with no loss or duplication. 300 faulted transfers -> ERR_CNT=255 (saturated).
6. Three transactions in flight, IN_RST_N low for one edge -> all outputs 0 next cycle, no result appears in the following 8 cycles, ERR_CNT=0.
